// File: rtl/spm_stream_port.sv
// Strided scratchpad stream port: moves `count` words between the scratchpad
// request/response bus and a valid/ready lane, in address-sequence order.
module spm_stream_port #(
    parameter int A_W        = 10,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [A_W-1:0] base,
    input  logic [A_W-1:0] stride,
    input  logic [A_W-1:0] count,
    input  logic [1:0]     fifo_sel_cfg,
    output logic           busy,
    output logic           done,
    input  logic [31:0]    wr_data,
    input  logic           wr_valid,
    output logic           wr_ready,
    output logic [31:0]    rd_data,
    output logic           rd_valid,
    input  logic           rd_ready,
    output logic [46:0]    spm_req,
    input  logic [31:0]    spm_rsp
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e          state_q;
    logic            mode_q;
    logic [A_W-1:0]  addr_q;
    logic [A_W-1:0]  stride_q;
    logic [A_W-1:0]  rem_q;
    logic [1:0]      fsel_q;
    logic [46:0]     req_q;
    logic            busy_q;
    logic            done_q;

    logic [RD_LAT-1:0] pipe_q;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [CW-1:0]     occ_q;
    logic [CW-1:0]     occ_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;

    logic            wr_hs;
    logic            ld_issue;
    logic            push;
    logic            pop;
    logic            last_word;
    logic [9:0]      addr_field;

    // cnt_q counts loads issued but not yet popped, so it covers both the
    // in-flight reads and FIFO occupancy; a same-cycle pop frees one credit.
    always_comb begin
        wr_ready   = (state_q == RUN) && mode_q && (rem_q != '0);
        rd_valid   = (occ_q != '0);
        rd_data    = mem_q[rptr_q];
        wr_hs      = wr_ready && wr_valid;
        pop        = rd_valid && rd_ready;
        push       = pipe_q[RD_LAT-1];
        ld_issue   = (state_q == RUN) && !mode_q && (rem_q != '0) &&
                     ((cnt_q < CW'(FIFO_DEPTH)) || pop);
        last_word  = (rem_q == A_W'(1));
        addr_field = 10'(addr_q);
        occ_d      = occ_q + CW'(push) - CW'(pop);
        cnt_d      = cnt_q + CW'(ld_issue) - CW'(pop);
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign spm_req = req_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            fsel_q   <= '0;
            req_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            req_q[44:43] <= 2'b00;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        addr_q   <= base;
                        stride_q <= stride;
                        rem_q    <= count;
                        fsel_q   <= fifo_sel_cfg;
                        if (count != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (wr_hs || ld_issue) begin
                        req_q <= {fsel_q, wr_hs, ld_issue, 1'b0, addr_field,
                                  wr_hs ? wr_data : req_q[31:0]};
                        addr_q <= addr_q + stride_q;
                        rem_q  <= rem_q - A_W'(1);
                        if (last_word) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (mode_q || (cnt_q == '0)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // pipe_q tracks outstanding reads so a response is captured exactly
    // RD_LAT cycles after its ren was on the bus; reset drops stale ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= req_q[43];
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (push) begin
                mem_q[wptr_q] <= spm_rsp;
                wptr_q <= (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
            end
            occ_q <= occ_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_spm_stream_port.sv
// Directed bench for spm_stream_port with a fixed-latency scratchpad model
// whose read data is {generation tag, address}.
module tb_spm_stream_port;

    localparam int A_W        = 10;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [9:0]  base = '0;
    logic [9:0]  stride = '0;
    logic [9:0]  count = '0;
    logic [1:0]  fsel = '0;
    logic        busy;
    logic        done;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [46:0] spm_req;
    logic [31:0] spm_rsp;

    spm_stream_port #(.A_W(A_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .base(base), .stride(stride), .count(count), .fifo_sel_cfg(fsel),
        .busy(busy), .done(done),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .spm_req(spm_req), .spm_rsp(spm_rsp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scratchpad model: two-stage read pipe.
    logic [7:0] gen = 8'h00;
    logic       s0v = 1'b0, s1v = 1'b0;
    logic [9:0] s0a = '0, s1a = '0;
    logic [7:0] s0g = '0, s1g = '0;
    always @(posedge clk) begin
        s0v <= spm_req[43];
        s0a <= spm_req[41:32];
        s0g <= gen;
        s1v <= s0v;
        s1a <= s0a;
        s1g <= s0g;
    end
    assign spm_rsp = s1v ? {s1g, 14'h0, s1a} : 32'hDEAD_BEEF;

    // Bus / lane monitor.
    logic [9:0]  wq[$];
    logic [9:0]  rq[$];
    logic [31:0] wdq[$];
    logic [31:0] dq[$];
    int          wcyc[$];
    int          done_cnt = 0;
    int          viol = 0;
    int          first_ren = -1;
    int          first_rv = -1;
    logic [1:0]  lfsel = '0;

    always @(negedge clk) begin
        if (spm_req[44]) begin
            wq.push_back(spm_req[41:32]);
            wdq.push_back(spm_req[31:0]);
            wcyc.push_back(cyc);
        end
        if (spm_req[43]) begin
            rq.push_back(spm_req[41:32]);
            if (first_ren < 0) first_ren = cyc;
        end
        if (spm_req[44] || spm_req[43]) lfsel = spm_req[46:45];
        if ((spm_req[44] && spm_req[43]) || spm_req[42]) viol++;
        if (rd_valid && rd_ready) dq.push_back(rd_data);
        if (rd_valid && first_rv < 0) first_rv = cyc;
        if (done) done_cnt++;
    end

    int pass = 0;
    int total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_mon();
        wq.delete(); rq.delete(); wdq.delete(); dq.delete(); wcyc.delete();
        done_cnt  = 0;
        first_ren = -1;
        first_rv  = -1;
    endtask

    task automatic wait_done(input int budget);
        logic hs;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            hs = wr_valid && wr_ready;
            if (done) break;
            @(posedge clk); #1;
            if (hs) wr_data = wr_data + 32'd1;
        end
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_cmd(input logic m, input logic [9:0] b, input logic [9:0] s,
                           input logic [9:0] c, input logic [1:0] f);
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; mode = m; base = b; stride = s; count = c; fsel = f;
        wr_valid = m; wr_data = 32'hC0DE_0000; rd_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(80);
    endtask

    typedef struct {
        logic       m;
        logic [9:0] b, s, c, fa, la;
        logic [1:0] fs;
    } vec_t;

    vec_t tbl [6];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] q[$];
        tbl[0] = '{m:1'b1, b:10'h3F0, s:10'h008, c:10'd4, fa:10'h3F0, la:10'h008, fs:2'b10};
        tbl[1] = '{m:1'b1, b:10'h000, s:10'h001, c:10'd3, fa:10'h000, la:10'h002, fs:2'b01};
        tbl[2] = '{m:1'b1, b:10'h3FF, s:10'h3FF, c:10'd2, fa:10'h3FF, la:10'h3FE, fs:2'b11};
        tbl[3] = '{m:1'b0, b:10'h005, s:10'h001, c:10'd8, fa:10'h005, la:10'h00C, fs:2'b00};
        tbl[4] = '{m:1'b0, b:10'h100, s:10'h100, c:10'd5, fa:10'h100, la:10'h100, fs:2'b10};
        tbl[5] = '{m:1'b0, b:10'h007, s:10'h000, c:10'd1, fa:10'h007, la:10'h007, fs:2'b01};

        #1 rst = 1'b0;
        #20;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("rst_req", {31'b0, |spm_req}, 0);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_cmd(tbl[i].m, tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].fs);
            if (tbl[i].m) q = wq; else q = rq;
            chk($sformatf("v%0d_nwords", i), 32'(q.size()), 32'(tbl[i].c));
            if (q.size() > 0) begin
                chk($sformatf("v%0d_first_addr", i), 32'(q[0]), 32'(tbl[i].fa));
                chk($sformatf("v%0d_last_addr", i), 32'(q[q.size()-1]), 32'(tbl[i].la));
            end
            chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 1);
            chk($sformatf("v%0d_fsel", i), 32'(lfsel), 32'(tbl[i].fs));
            if (tbl[i].m) begin
                chk($sformatf("v%0d_no_ren", i), 32'(rq.size()), 0);
                if (wdq.size() > 0) begin
                    chk($sformatf("v%0d_first_data", i), wdq[0], 32'hC0DE_0000);
                    chk($sformatf("v%0d_last_data", i), wdq[wdq.size()-1],
                        32'hC0DE_0000 + 32'(tbl[i].c) - 32'd1);
                    chk($sformatf("v%0d_wen_span", i), 32'(wcyc[wcyc.size()-1] - wcyc[0]),
                        32'(tbl[i].c) - 32'd1);
                end
            end else begin
                chk($sformatf("v%0d_ndata", i), 32'(dq.size()), 32'(tbl[i].c));
                if (dq.size() > 0) begin
                    chk($sformatf("v%0d_first_rd", i), dq[0], {22'b0, tbl[i].fa});
                    chk($sformatf("v%0d_last_rd", i), dq[dq.size()-1], {22'b0, tbl[i].la});
                end
                chk($sformatf("v%0d_rd_latency", i), 32'(first_rv - first_ren), 3);
            end
        end

        // Backpressure: credits stop issue at FIFO_DEPTH, then everything drains.
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; base = 10'h005; stride = 10'h001; count = 10'd8; rd_ready = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp_ren_stall", 32'(rq.size()), FIFO_DEPTH);
        chk("bp_rd_valid", {31'b0, rd_valid}, 1);
        chk("bp_busy", {31'b0, busy}, 1);
        chk("bp_hold0", rd_data, 32'h005);
        @(negedge clk);
        chk("bp_hold1", rd_data, 32'h005);
        @(posedge clk); #1 rd_ready = 1'b1;
        wait_done(80);
        chk("bp_ndata", 32'(dq.size()), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < dq.size()) chk($sformatf("bp_data%0d", k), dq[k], 32'(5 + k));
        end
        chk("bp_nren", 32'(rq.size()), 8);
        chk("bp_done_cnt", 32'(done_cnt), 1);

        // Zero-length command.
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; base = 10'h033; stride = 10'h001; count = 10'd0;
        @(negedge clk);
        chk("zc_done_early", {31'b0, done}, 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("zc_done", {31'b0, done}, 1);
        chk("zc_busy", {31'b0, busy}, 0);
        @(negedge clk);
        chk("zc_done_off", {31'b0, done}, 0);
        repeat (3) @(negedge clk);
        chk("zc_done_cnt", 32'(done_cnt), 1);
        chk("zc_no_access", 32'(wq.size() + rq.size()), 0);

        // Reset with two reads in flight; stale responses must be dropped.
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; base = 10'h020; stride = 10'h001; count = 10'd8; rd_ready = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        chk("ar_ren_on_bus", {31'b0, spm_req[43]}, 1);
        chk("ar_ren_prior", 32'(rq.size()), 1);
        rst = 1'b0;
        #1;
        chk("ar_busy", {31'b0, busy}, 0);
        chk("ar_done", {31'b0, done}, 0);
        chk("ar_wr_ready", {31'b0, wr_ready}, 0);
        chk("ar_rd_valid", {31'b0, rd_valid}, 0);
        chk("ar_req", {31'b0, |spm_req}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        gen = 8'h01;
        run_cmd(1'b0, 10'h040, 10'h001, 10'd2, 2'b00);
        chk("ar_ndata", 32'(dq.size()), 2);
        if (dq.size() > 0) chk("ar_data0", dq[0], 32'h0100_0040);
        if (dq.size() > 1) chk("ar_data1", dq[1], 32'h0100_0041);
        chk("ar_done_cnt", 32'(done_cnt), 1);

        // Start while busy is ignored.
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; base = 10'h010; stride = 10'h002; count = 10'd3;
        wr_valid = 1'b0; wr_data = 32'h5555_0000;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; base = 10'h200; stride = 10'h001; count = 10'd0;
        @(posedge clk); #1;
        start = 1'b0; wr_valid = 1'b1;
        wait_done(40);
        chk("sb_nwen", 32'(wq.size()), 3);
        if (wq.size() > 0) chk("sb_addr0", 32'(wq[0]), 32'h010);
        if (wq.size() > 2) chk("sb_addr2", 32'(wq[2]), 32'h014);
        if (wdq.size() > 0) chk("sb_data0", wdq[0], 32'h5555_0000);
        chk("sb_no_ren", 32'(rq.size()), 0);
        chk("sb_done_cnt", 32'(done_cnt), 1);
        chk("sb_busy_after", {31'b0, busy}, 0);

        chk("bus_invariant", 32'(viol), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
